// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and bit-timing constants for the USB RX path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        RUN     = 2'd2
    } rx_state_t;

    // Consecutive ones after which the transmitter must have inserted a zero.
    localparam int unsigned STUFF_LIMIT      = 6;

    localparam int unsigned DEF_CLKS_PER_BIT = 8;
    localparam int unsigned DEF_SAMPLE_PHASE = 4;
    // Matches the edge detector's 2-cycle latency.
    localparam int unsigned DEF_EDGE_OFFSET  = 2;

endpackage

// File: rtl/usb_rx_stuff_tracker.sv
// usb_rx_stuff_tracker: counts consecutive ones at bit sample points and flags
// the stuffed bit that must follow six ones. Only built with USB_RX_BITSTUFF_EN.
`ifdef USB_RX_BITSTUFF_EN
module usb_rx_stuff_tracker
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic sample_pt_i,
    input  logic d_orig_i,
    output logic stuff_pending_o,
    output logic stuff_err_o
);

    logic [2:0] ones_q, ones_d;
    logic       pending_q, pending_d;
    logic       err_q, err_d;

    // Next-state: a sample point either consumes the stuffed bit or updates the run of ones.
    always_comb begin
        ones_d    = ones_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        if (clear_i) begin
            ones_d    = '0;
            pending_d = 1'b0;
        end else if (sample_pt_i) begin
            if (pending_q) begin
                // Stuffed bit: must be 0; a 1 here is a stuffing violation.
                ones_d    = '0;
                pending_d = 1'b0;
                err_d     = d_orig_i;
            end else if (d_orig_i) begin
                ones_d    = ones_q + 3'd1;
                pending_d = (ones_q == 3'(STUFF_LIMIT - 1));
            end else begin
                ones_d = '0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q    <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ones_q    <= ones_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign stuff_pending_o = pending_q;
    assign stuff_err_o     = err_q;

endmodule
`endif

// File: rtl/usb_rx_bit_sequencer.sv
// usb_rx_bit_sequencer: locks a per-bit phase counter to D+ edges, strobes
// shift_enable at each bit centre, counts bits and flags completed bytes.
// Optional bit-stuff tracking is enabled with the USB_RX_BITSTUFF_EN macro.
module usb_rx_bit_sequencer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE = DEF_SAMPLE_PHASE,
    parameter int unsigned EDGE_OFFSET  = DEF_EDGE_OFFSET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    input  logic       d_orig,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [2:0] bit_count,
    output logic       stuff_err
);

    localparam int unsigned   PW        = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(SAMPLE_PHASE);
    localparam logic [PW-1:0] EDGE_PH   = PW'(EDGE_OFFSET);
    localparam logic [PW-1:0] LAST_PH   = PW'(CLKS_PER_BIT - 1);

    rx_state_t     state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_count_q, bit_count_d;
    logic          byte_received_q, byte_received_d;
    logic          sample_pt;
    logic          stuff_pending;
    logic          stuff_clear;

    // Strobe is decoded from registers only, so it is still emitted in the
    // cycle enable_timer falls.
    assign sample_pt    = (state_q == RUN) && (phase_q == SAMPLE_PH);
    assign shift_enable = sample_pt && !stuff_pending;
    assign stuff_clear  = !enable_timer;

`ifdef USB_RX_BITSTUFF_EN
    usb_rx_stuff_tracker u_stuff (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (stuff_clear),
        .sample_pt_i     (sample_pt),
        .d_orig_i        (d_orig),
        .stuff_pending_o (stuff_pending),
        .stuff_err_o     (stuff_err)
    );
`else
    logic unused_d_orig;
    logic unused_stuff_clear;
    assign unused_d_orig      = d_orig;
    assign unused_stuff_clear = stuff_clear;
    assign stuff_pending      = 1'b0;
    assign stuff_err          = 1'b0;
`endif

    // Next-state: sequencing, phase tracking and bit counting; disable overrides all.
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        bit_count_d     = bit_count_q;
        byte_received_d = 1'b0;
        if (!enable_timer) begin
            state_d     = IDLE;
            phase_d     = '0;
            bit_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ACQUIRE;
                ACQUIRE: begin
                    if (d_edge) begin
                        state_d = RUN;
                        phase_d = EDGE_PH;
                    end
                end
                RUN: begin
                    if (d_edge) begin
                        phase_d = EDGE_PH;
                    end else if (phase_q == LAST_PH) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (shift_enable) begin
                bit_count_d     = bit_count_q + 3'd1;
                byte_received_d = (bit_count_q == 3'd7);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            bit_count_q     <= '0;
            byte_received_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            bit_count_q     <= bit_count_d;
            byte_received_q <= byte_received_d;
        end
    end

    assign bit_count     = bit_count_q;
    assign byte_received = byte_received_q;

endmodule
